// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier operand sequencer: default sizing and FSM state encodings.
package mul_pkg;

    localparam int MUL_WIDTH      = 16;
    localparam int MUL_FIFO_DEPTH = 4;
    localparam int MUL_TIMEOUT    = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/mul_op_fifo.sv
// Synchronous operand-pair FIFO with count-based full/empty; DEPTH must be a power of two.
module mul_op_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mul_op_sequencer.sv
// Feeds queued operand pairs to the shift-add multiplier one at a time and returns products in order.
module mul_op_sequencer
    import mul_pkg::*;
#(
    parameter int WIDTH      = MUL_WIDTH,
    parameter int FIFO_DEPTH = MUL_FIFO_DEPTH,
    parameter int TIMEOUT    = MUL_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_data,
    output logic               err,
    output logic               busy,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_ain,
    output logic [WIDTH-1:0]   mul_bin,
    input  logic [2*WIDTH-1:0] mul_yout,
    input  logic               mul_done
);

    localparam int CNT_W = $clog2(TIMEOUT);

    seq_state_t         state;
    seq_state_t         state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               res_valid_nxt;
    logic [2*WIDTH-1:0] res_data_nxt;
    logic               err_nxt;
    logic               start_nxt;
    logic [WIDTH-1:0]   ain_nxt;
    logic [WIDTH-1:0]   bin_nxt;
    logic               fifo_pop;
    logic [2*WIDTH-1:0] fifo_rd;
    logic               fifo_full;
    logic               fifo_empty;

    mul_op_fifo #(
        .DATA_W (2*WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (in_valid),
        .wr_data ({in_a, in_b}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign in_ready = !fifo_full;
    assign busy     = (state != ST_IDLE) || !fifo_empty;

    // Operands stay latched on mul_ain/mul_bin for the whole op, so the
    // multiplier sees stable inputs from the rise of start until its fall.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        res_valid_nxt = res_valid;
        res_data_nxt  = res_data;
        err_nxt       = 1'b0;
        start_nxt     = mul_start;
        ain_nxt       = mul_ain;
        bin_nxt       = mul_bin;
        fifo_pop      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    ain_nxt   = fifo_rd[2*WIDTH-1:WIDTH];
                    bin_nxt   = fifo_rd[WIDTH-1:0];
                    start_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_nxt = cnt + 1'b1;
                // Done wins over timeout so a product on the last counted cycle is kept.
                if (mul_done) begin
                    res_data_nxt  = mul_yout;
                    res_valid_nxt = 1'b1;
                    start_nxt     = 1'b0;
                    state_nxt     = ST_OUT;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    start_nxt = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            ST_OUT: begin
                start_nxt = 1'b0;
                if (res_valid && res_ready) begin
                    res_valid_nxt = 1'b0;
                    state_nxt     = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            err       <= 1'b0;
            mul_start <= 1'b0;
            mul_ain   <= '0;
            mul_bin   <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            res_valid <= res_valid_nxt;
            res_data  <= res_data_nxt;
            err       <= err_nxt;
            mul_start <= start_nxt;
            mul_ain   <= ain_nxt;
            mul_bin   <= bin_nxt;
        end
    end

endmodule

// File: tb/tb_mul_op_sequencer.sv
// Bench for mul_op_sequencer: behavioural shift-add multiplier, in-order scoreboard and directed vectors.
module tb_mul_op_sequencer;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int TMO   = 32;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } op_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [2*W-1:0] res_data;
    logic           err;
    logic           busy;
    logic           mul_start;
    logic [W-1:0]   mul_ain;
    logic [W-1:0]   mul_bin;
    logic [2*W-1:0] mul_yout;
    logic           mul_done;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    mul_op_sequencer #(.WIDTH(W), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .err       (err),
        .busy      (busy),
        .mul_start (mul_start),
        .mul_ain   (mul_ain),
        .mul_bin   (mul_bin),
        .mul_yout  (mul_yout),
        .mul_done  (mul_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [2*W-1:0] actual,
                               input logic [2*W-1:0] expected);
        assert_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Multiplier model: latches operands after start rises, done after 16 cycles, re-arms on start low.
    logic           stub_done = 1'b0;
    logic           m_running;
    logic           m_done;
    int             m_cyc;
    logic [W-1:0]   m_a;
    logic [W-1:0]   m_b;
    logic [2*W-1:0] m_yout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_running <= 1'b0; m_done <= 1'b0; m_cyc <= 0;
            m_a <= '0; m_b <= '0; m_yout <= '0;
        end else if (!mul_start) begin
            m_running <= 1'b0; m_done <= 1'b0; m_cyc <= 0;
        end else if (!m_running) begin
            m_running <= 1'b1; m_a <= mul_ain; m_b <= mul_bin; m_cyc <= 0;
        end else if (!m_done) begin
            if (m_cyc == 15) begin
                m_done <= 1'b1;
                m_yout <= {16'd0, m_a} * {16'd0, m_b};
            end else begin
                m_cyc <= m_cyc + 1;
            end
        end
    end

    assign mul_done = m_done && !stub_done;
    assign mul_yout = m_done ? m_yout : 32'hDEAD_BEEF;

    // Scoreboard: every accepted pair is owed exactly one product or one err pulse, in order.
    op_t            exp_q[$];
    logic [2*W-1:0] got_q[$];
    logic           front_started = 1'b0;
    int             run_cnt = 0;
    int             last_err_cnt = 0;
    int             rv_cycles = 0;
    logic           seen_not_ready = 1'b0;
    logic           prev_start = 1'b0;
    logic           prev_err = 1'b0;
    logic           prev_rv = 1'b0;
    logic           prev_rr = 1'b0;
    logic [2*W-1:0] prev_rd = '0;
    int             occ;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            front_started = 1'b0;
            checkOutput("rst_res_valid", res_valid, 0);
            checkOutput("rst_res_data", res_data, 0);
            checkOutput("rst_err", err, 0);
            checkOutput("rst_mul_start", mul_start, 0);
            checkOutput("rst_mul_ain", mul_ain, 0);
            checkOutput("rst_mul_bin", mul_bin, 0);
            checkOutput("rst_in_ready", in_ready, 1);
            checkOutput("rst_busy", busy, 0);
            prev_start = 1'b0; prev_err = 1'b0; prev_rv = 1'b0; prev_rr = 1'b0; prev_rd = '0;
        end else begin
            run_cnt++;
            if (prev_err) checkOutput("err_one_cycle", err, 0);
            if (err) begin
                checkOutput("timeout_cycles", run_cnt, TMO);
                last_err_cnt = run_cnt;
                if (exp_q.size() == 0) checkOutput("err_without_op", 1, 0);
                else void'(exp_q.pop_front());
                front_started = 1'b0;
            end
            if (mul_start && !prev_start) begin
                checkOutput("start_has_op", (exp_q.size() > 0 && !front_started), 1);
                front_started = 1'b1;
                run_cnt = 0;
            end
            if (mul_start && exp_q.size() > 0) begin
                checkOutput("mul_ain", mul_ain, exp_q[0].a);
                checkOutput("mul_bin", mul_bin, exp_q[0].b);
            end
            checkOutput("busy", busy, exp_q.size() != 0);
            occ = exp_q.size() - (front_started ? 1 : 0);
            checkOutput("in_ready", in_ready, occ < DEPTH);
            if (prev_rv && !prev_rr) begin
                checkOutput("res_valid_hold", res_valid, 1);
                checkOutput("res_data_hold", res_data, prev_rd);
            end
            if (res_valid) begin
                rv_cycles++;
                checkOutput("start_low_in_out", mul_start, 0);
                if (exp_q.size() == 0) checkOutput("res_without_op", 1, 0);
                else checkOutput("res_data", res_data, exp_q[0].p);
                if (res_ready) begin
                    got_q.push_back(res_data);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    front_started = 1'b0;
                end
            end
            if (in_valid && !in_ready) seen_not_ready = 1'b1;
            if (in_valid && in_ready)
                exp_q.push_back('{a: in_a, b: in_b, p: {16'd0, in_a} * {16'd0, in_b}});
            prev_start = mul_start; prev_err = err;
            prev_rv = res_valid; prev_rr = res_ready; prev_rd = res_data;
        end
    end

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        logic ok;
        int   guard;
        in_valid = 1'b1; in_a = a; in_b = b;
        guard = 0;
        do begin
            ok = in_ready;
            @(posedge clk); #1;
            guard++;
        end while (!ok && guard < 300);
        if (!ok) checkOutput("push_accept_timeout", 0, 1);
    endtask

    task automatic endStimulus();
        in_valid = 1'b0;
    endtask

    task automatic waitResults(input int n, input int budget);
        int guard = 0;
        while (got_q.size() < n && guard < budget) begin
            @(posedge clk); #2;
            guard++;
        end
        if (got_q.size() < n) checkOutput("wait_results", got_q.size(), n);
    endtask

    task automatic waitIdle();
        int guard = 0;
        while ((busy || res_valid) && guard < 300) begin
            @(posedge clk); #2;
            guard++;
        end
        if (busy) checkOutput("wait_idle", busy, 0);
    endtask

    function automatic logic [2*W-1:0] gotAt(input int i);
        if (i < got_q.size()) return got_q[i];
        return 32'hBAD0_BAD0;
    endfunction

    int exp3 [6] = '{2, 6, 12, 20, 30, 42};

    initial begin
        int guard;
        #2;
        checkOutput("init_res_valid", res_valid, 0);
        checkOutput("init_mul_start", mul_start, 0);
        checkOutput("init_in_ready", in_ready, 1);
        checkOutput("init_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] single product 3*5");
        res_ready = 1'b1; got_q.delete(); rv_cycles = 0;
        applyStimulus(16'd3, 16'd5); endStimulus();
        waitResults(1, 100);
        checkOutput("t1_product", gotAt(0), 32'd15);
        waitIdle();
        checkOutput("t1_res_valid_cycles", rv_cycles, 1);

        $display("[TB] extreme operands");
        got_q.delete();
        applyStimulus(16'hFFFF, 16'hFFFF);
        applyStimulus(16'h0000, 16'h1234); endStimulus();
        waitResults(2, 200);
        checkOutput("t2_max", gotAt(0), 32'hFFFE_0001);
        checkOutput("t2_zero", gotAt(1), 32'd0);
        waitIdle();

        $display("[TB] back-to-back burst");
        got_q.delete(); seen_not_ready = 1'b0;
        for (int k = 1; k <= 6; k++) applyStimulus(W'(k), W'(k + 1));
        endStimulus();
        waitResults(6, 400);
        for (int i = 0; i < 6; i++) checkOutput("t3_product", gotAt(i), exp3[i]);
        checkOutput("t3_in_ready_dropped", seen_not_ready, 1);
        waitIdle();

        $display("[TB] downstream stall");
        got_q.delete(); res_ready = 1'b0;
        applyStimulus(16'd7, 16'd9);
        applyStimulus(16'd100, 16'd200); endStimulus();
        guard = 0;
        while (!res_valid && guard < 100) begin @(posedge clk); #2; guard++; end
        repeat (50) @(posedge clk);
        #2;
        checkOutput("t4_valid_held", res_valid, 1);
        checkOutput("t4_data_held", res_data, 32'd63);
        checkOutput("t4_start_low", mul_start, 0);
        res_ready = 1'b1;
        waitResults(2, 200);
        checkOutput("t4_first", gotAt(0), 32'd63);
        checkOutput("t4_second", gotAt(1), 32'd20000);
        waitIdle();

        $display("[TB] multiplier timeout");
        got_q.delete(); stub_done = 1'b1; rv_cycles = 0; last_err_cnt = 0;
        applyStimulus(16'd2, 16'd3);
        applyStimulus(16'd4, 16'd5); endStimulus();
        guard = 0;
        while (!err && guard < 200) begin @(posedge clk); #2; guard++; end
        checkOutput("t5_err_seen", err, 1);
        checkOutput("t5_start_dropped", mul_start, 0);
        @(posedge clk); #2;
        checkOutput("t5_err_cleared", err, 0);
        checkOutput("t5_next_start", mul_start, 1);
        checkOutput("t5_err_delay", last_err_cnt, 32);
        guard = 0;
        while (!err && guard < 200) begin @(posedge clk); #2; guard++; end
        checkOutput("t5_second_err", err, 1);
        stub_done = 1'b0;
        waitIdle();
        checkOutput("t5_no_result", rv_cycles, 0);

        $display("[TB] reset mid-run");
        got_q.delete();
        for (int k = 1; k <= 4; k++) applyStimulus(W'(k), W'(k));
        endStimulus();
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t6_running", mul_start, 1);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("t6_res_valid", res_valid, 0);
        checkOutput("t6_start", mul_start, 0);
        checkOutput("t6_ain", mul_ain, 0);
        checkOutput("t6_in_ready", in_ready, 1);
        checkOutput("t6_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(16'd11, 16'd13); endStimulus();
        waitResults(1, 100);
        checkOutput("t6_fresh_product", gotAt(0), 32'd143);
        waitIdle();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
